// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller.
// Holds the CP0 cause encodings, the CP0 status bit positions used for
// masking, the pending-vector bit positions and the controller FSM encoding.
package exc_pkg;

    // Cause codes driven into CP0
    localparam logic [1:0] CAUSE_SYSCALL = 2'b00;
    localparam logic [1:0] CAUSE_BREAK   = 2'b01;
    localparam logic [1:0] CAUSE_TEQ     = 2'b11;

    // CP0 status bit indices
    localparam int IE       = 0;
    localparam int SYS_MASK = 1;
    localparam int BRK_MASK = 2;
    localparam int TEQ_MASK = 3;

    // Bit positions inside the pending vector {teq, break, syscall}
    localparam int SRC_SYSCALL = 0;
    localparam int SRC_BREAK   = 1;
    localparam int SRC_TEQ     = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTER   = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_HANDLER = 3'd3,
        ST_RETURN  = 3'd4
    } exc_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Masked priority encoder for pending exception sources.
// A pending bit is eligible when the global enable (IE) and its own mask bit
// are both set. Among eligible bits teq wins over break, break over syscall.
// Ports:
//   pending_i  [2:0]  pending vector {teq, break, syscall}
//   status_i   [3:0]  low bits of CP0 status {teq_mask, brk_mask, sys_mask, ie}
//   valid_o           at least one eligible pending bit
//   cause_o    [1:0]  CP0 cause code of the winner
//   clear_o    [2:0]  one-hot mask of the winning pending bit
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [2:0] pending_i,
    input  logic [3:0] status_i,
    output logic       valid_o,
    output logic [1:0] cause_o,
    output logic [2:0] clear_o
);

    logic [2:0] elig;

    always_comb begin
        elig    = pending_i & status_i[TEQ_MASK:SYS_MASK] & {3{status_i[IE]}};
        valid_o = |elig;
        cause_o = CAUSE_SYSCALL;
        clear_o = 3'b000;
        if (elig[SRC_TEQ]) begin
            cause_o = CAUSE_TEQ;
            clear_o = 3'b100;
        end else if (elig[SRC_BREAK]) begin
            cause_o = CAUSE_BREAK;
            clear_o = 3'b010;
        end else if (elig[SRC_SYSCALL]) begin
            cause_o = CAUSE_SYSCALL;
            clear_o = 3'b001;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception request generator / arbiter, initiator side of the CP0
// exception interface.
// Latches syscall/break/teq events as pending, arbitrates the ones enabled by
// CP0 status, emits a one-cycle exception pulse with cause and EPC, and
// redirects the PC to the handler on entry and to EPC+4 on eret. Each redirect
// is followed by FLUSH_CYCLES cycles of stall.
// Handshake: exception_o and eret_o are registered single-cycle pulses; CP0
// samples them on the negedge inside that cycle and gives no acknowledge.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   syscall_i/break_i/teq_i  decoded exception sources, one-cycle
//   eret_i                   decoded eret, one-cycle
//   pc_i                     PC of the instruction in decode
//   status_i                 CP0 status
//   exc_addr_i               CP0 EPC+4
//   exception_o, cause_o, epc_o   exception request to CP0
//   eret_o                   eret request to CP0
//   redirect_o, target_o     PC mux select and target
//   stall_o                  freeze fetch/decode
//   pending_o                pending vector {teq, break, syscall}
//   state_o                  current FSM state (debug)
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0040_0004,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        teq_i,
    input  logic        eret_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] status_i,
    input  logic [31:0] exc_addr_i,
    output logic        exception_o,
    output logic [1:0]  cause_o,
    output logic [31:0] epc_o,
    output logic        eret_o,
    output logic        redirect_o,
    output logic [31:0] target_o,
    output logic        stall_o,
    output logic [2:0]  pending_o,
    output exc_state_e  state_o
);

    // The flush counter counts down to zero, so FLUSH lasts FLUSH_CYCLES cycles
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    exc_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        ret_q, ret_d;          // current FLUSH ends in IDLE (after eret)
    logic [2:0]  pending_q, pending_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    logic        exception_q, exception_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic        eret_q, eret_d;
    logic        redirect_q, redirect_d;
    logic [31:0] target_q, target_d;
    logic        stall_q, stall_d;

    logic        win_valid;
    logic [1:0]  win_cause;
    logic [2:0]  win_clear;
    logic [2:0]  clear;
    logic [2:0]  src;
    logic [2:0]  kept;

    // Only the IE and per-source mask bits matter here
    logic unused_status;
    assign unused_status = ^status_i[31:4];

    exc_prio_enc u_prio (
        .pending_i (pending_q),
        .status_i  (status_i[3:0]),
        .valid_o   (win_valid),
        .cause_o   (win_cause),
        .clear_o   (win_clear)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ret_d       = ret_q;
        clear       = 3'b000;
        exception_d = 1'b0;
        cause_d     = CAUSE_SYSCALL;
        epc_d       = 32'h0;
        eret_d      = 1'b0;
        redirect_d  = 1'b0;
        target_d    = 32'h0;
        stall_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d = ST_ENTER;
                    clear   = win_clear;
                end else if (eret_i) begin
                    state_d = ST_RETURN;
                end
            end
            ST_ENTER: begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_LAST;
                ret_d   = 1'b0;
            end
            ST_FLUSH: begin
                // eret_i is deliberately ignored while flushing
                if (cnt_q == 3'd0) begin
                    state_d = ret_q ? ST_IDLE : ST_HANDLER;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_HANDLER: begin
                if (eret_i) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_LAST;
                ret_d   = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered: they describe the cycle spent in state_d.
        // ENTER is only reached from IDLE with a valid winner, so the
        // encoder outputs are meaningful on that transition.
        case (state_d)
            ST_ENTER: begin
                exception_d = 1'b1;
                cause_d     = win_cause;
                epc_d       = pend_pc_q;
                redirect_d  = 1'b1;
                target_d    = HANDLER_ADDR;
                stall_d     = 1'b1;
            end
            ST_RETURN: begin
                eret_d     = 1'b1;
                redirect_d = 1'b1;
                target_d   = exc_addr_i;
                stall_d    = 1'b1;
            end
            ST_FLUSH: begin
                stall_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Pending latch. New events are OR-ed after the winner is cleared so a
    // source arriving on the ENTER edge is never lost. The shared PC is only
    // captured when nothing remains pending.
    always_comb begin
        src       = {teq_i, break_i, syscall_i};
        kept      = pending_q & ~clear;
        pending_d = kept | src;
        pend_pc_d = pend_pc_q;
        if ((kept == 3'b000) && (src != 3'b000)) begin
            pend_pc_d = pc_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            ret_q       <= 1'b0;
            pending_q   <= 3'b000;
            pend_pc_q   <= 32'h0;
            exception_q <= 1'b0;
            cause_q     <= CAUSE_SYSCALL;
            epc_q       <= 32'h0;
            eret_q      <= 1'b0;
            redirect_q  <= 1'b0;
            target_q    <= 32'h0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ret_q       <= ret_d;
            pending_q   <= pending_d;
            pend_pc_q   <= pend_pc_d;
            exception_q <= exception_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            eret_q      <= eret_d;
            redirect_q  <= redirect_d;
            target_q    <= target_d;
            stall_q     <= stall_d;
        end
    end

    assign exception_o = exception_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign eret_o      = eret_q;
    assign redirect_o  = redirect_q;
    assign target_o    = target_q;
    assign stall_o     = stall_q;
    assign pending_o   = pending_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;
    import exc_pkg::*;

    localparam logic [31:0] HANDLER = 32'h0040_0004;
    localparam int          FLUSH   = 2;

    logic        clk;
    logic        rst;
    logic        syscall_i, break_i, teq_i, eret_i;
    logic [31:0] pc_i, status_i, exc_addr_i;
    logic        exception_o;
    logic [1:0]  cause_o;
    logic [31:0] epc_o;
    logic        eret_o;
    logic        redirect_o;
    logic [31:0] target_o;
    logic        stall_o;
    logic [2:0]  pending_o;
    exc_state_e  state_o;

    exc_ctrl #(.HANDLER_ADDR(HANDLER), .FLUSH_CYCLES(FLUSH)) dut (
        .clk         (clk),
        .rst         (rst),
        .syscall_i   (syscall_i),
        .break_i     (break_i),
        .teq_i       (teq_i),
        .eret_i      (eret_i),
        .pc_i        (pc_i),
        .status_i    (status_i),
        .exc_addr_i  (exc_addr_i),
        .exception_o (exception_o),
        .cause_o     (cause_o),
        .epc_o       (epc_o),
        .eret_o      (eret_o),
        .redirect_o  (redirect_o),
        .target_o    (target_o),
        .stall_o     (stall_o),
        .pending_o   (pending_o),
        .state_o     (state_o)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int stall_seen;
    bit exc_seen;

    // Reference model: a schedule of expected output cycles. Starting an
    // exception or a return enqueues the redirect cycle followed by the
    // stall cycles; the edge after a stall run never starts a new sequence.
    typedef struct packed {
        logic        exc;
        logic [1:0]  cause;
        logic [31:0] epc;
        logic        eret;
        logic        redir;
        logic [31:0] target;
        logic        stall;
    } exp_t;

    exp_t       sched[$];
    exp_t       cur;
    logic [2:0] m_pend;
    logic [31:0] m_ppc;
    bit         in_handler;

    task automatic model_reset();
        sched.delete();
        cur        = '0;
        m_pend     = 3'b000;
        m_ppc      = 32'h0;
        in_handler = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic b, input logic t, input logic e);
        exp_t       nxt;
        exp_t       fl;
        logic [2:0] elig;
        logic [2:0] src;
        int         win;
        nxt      = '0;
        fl       = '0;
        fl.stall = 1'b1;
        elig = m_pend & status_i[3:1] & {3{status_i[0]}};
        if (sched.size() > 0) begin
            nxt = sched.pop_front();
        end else if (!cur.stall) begin
            if (!in_handler && elig != 3'b000) begin
                win = elig[2] ? 2 : (elig[1] ? 1 : 0);
                nxt.exc    = 1'b1;
                nxt.cause  = (win == 2) ? 2'b11 : ((win == 1) ? 2'b01 : 2'b00);
                nxt.epc    = m_ppc;
                nxt.redir  = 1'b1;
                nxt.target = HANDLER;
                nxt.stall  = 1'b1;
                for (int i = 0; i < FLUSH; i++) sched.push_back(fl);
                m_pend[win] = 1'b0;
                in_handler  = 1'b1;
            end else if (e) begin
                nxt.eret   = 1'b1;
                nxt.redir  = 1'b1;
                nxt.target = exc_addr_i;
                nxt.stall  = 1'b1;
                for (int i = 0; i < FLUSH; i++) sched.push_back(fl);
                in_handler = 1'b0;
            end
        end
        cur = nxt;
        src = {t, b, s};
        if (m_pend == 3'b000 && src != 3'b000) m_ppc = pc_i;
        m_pend = m_pend | src;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        chk("exception", 32'(exception_o), 32'(cur.exc));
        chk("cause",     32'(cause_o),     32'(cur.cause));
        chk("epc",       epc_o,            cur.epc);
        chk("eret",      32'(eret_o),      32'(cur.eret));
        chk("redirect",  32'(redirect_o),  32'(cur.redir));
        chk("target",    target_o,         cur.target);
        chk("stall",     32'(stall_o),     32'(cur.stall));
        chk("pending",   32'(pending_o),   32'(m_pend));
        chk("exc_eret_excl", 32'(exception_o & eret_o), 32'h0);
    endtask

    // one clock: drive, edge, update model, sample 1ns after the edge
    task automatic tick(input logic s, input logic b, input logic t, input logic e);
        syscall_i = s;
        break_i   = b;
        teq_i     = t;
        eret_i    = e;
        @(posedge clk);
        model_step(s, b, t, e);
        #1;
        check_outputs();
        if (exception_o) exc_seen = 1'b1;
        if (stall_o) stall_seen++;
        syscall_i = 1'b0;
        break_i   = 1'b0;
        teq_i     = 1'b0;
        eret_i    = 1'b0;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
    endtask

    // bounded wait for the exception pulse; returns cycles taken (0 = timeout)
    task automatic run_until_exc(input int budget, output int taken);
        taken = 0;
        for (int i = 1; i <= budget; i++) begin
            tick(0, 0, 0, 0);
            if (exception_o) begin
                taken = i;
                break;
            end
        end
    endtask

    int n;

    initial begin
        rst        = 1'b0;
        syscall_i  = 1'b0;
        break_i    = 1'b0;
        teq_i      = 1'b0;
        eret_i     = 1'b0;
        pc_i       = 32'h0;
        status_i   = 32'h0;
        exc_addr_i = 32'h0;
        model_reset();
        #12;
        // reset state
        chk("rst_exception", 32'(exception_o), 32'h0);
        chk("rst_pending",   32'(pending_o),   32'h0);
        chk("rst_stall",     32'(stall_o),     32'h0);
        chk("rst_target",    target_o,         32'h0);
        rst = 1'b1;
        #1;

        // 1: basic syscall entry
        status_i = 32'h0000_000F;
        pc_i     = 32'h0040_0020;
        tick(1, 0, 0, 0);
        stall_seen = 0;
        tick(0, 0, 0, 0);
        chk("t1_exception", 32'(exception_o), 32'h1);
        chk("t1_cause",     32'(cause_o),     32'h0);
        chk("t1_epc",       epc_o,            32'h0040_0020);
        chk("t1_target",    target_o,         32'h0040_0004);
        idle_n(3);
        chk("t1_stall_total", 32'(stall_seen), 32'd3);
        exc_addr_i = 32'h0040_0024;
        tick(0, 0, 0, 1);
        chk("t1_eret",   32'(eret_o), 32'h1);
        chk("t1_rtarget", target_o,   32'h0040_0024);
        idle_n(3);

        // 2: simultaneous teq + syscall, teq first then syscall with shared PC
        pc_i = 32'h0040_0040;
        tick(1, 0, 1, 0);
        pc_i = 32'h0;
        tick(0, 0, 0, 0);
        chk("t2_cause1",  32'(cause_o),   32'h3);
        chk("t2_pending", 32'(pending_o), 32'h1);
        idle_n(3);
        exc_addr_i = 32'h0040_0044;
        tick(0, 0, 0, 1);
        chk("t2_eret",    32'(eret_o), 32'h1);
        chk("t2_rtarget", target_o,    32'h0040_0044);
        run_until_exc(10, n);
        chk("t2_second_latency", 32'(n), 32'd4);
        chk("t2_cause2", 32'(cause_o), 32'h0);
        chk("t2_epc2",   epc_o,        32'h0040_0040);
        idle_n(3);
        tick(0, 0, 0, 1);
        idle_n(3);

        // 3: masked syscall, released by enabling its mask
        status_i = 32'h0000_0001;
        pc_i     = 32'h0040_0080;
        exc_seen = 1'b0;
        tick(1, 0, 0, 0);
        idle_n(3);
        chk("t3_no_exc",  32'(exc_seen),  32'h0);
        chk("t3_pending", 32'(pending_o), 32'h1);
        status_i = 32'h0000_0003;
        tick(0, 0, 0, 0);
        chk("t3_exception", 32'(exception_o), 32'h1);
        chk("t3_cause",     32'(cause_o),     32'h0);
        idle_n(3);
        tick(0, 0, 0, 1);
        idle_n(3);

        // 4: global disable keeps break pending
        status_i = 32'h0000_000E;
        exc_seen = 1'b0;
        tick(0, 1, 0, 0);
        idle_n(3);
        chk("t4_no_exc",  32'(exc_seen),  32'h0);
        chk("t4_pending", 32'(pending_o), 32'h2);
        status_i = 32'h0000_000F;
        tick(0, 0, 0, 0);
        chk("t4_cause", 32'(cause_o), 32'h1);
        idle_n(3);
        tick(0, 0, 0, 1);
        idle_n(3);

        // 5: break during HANDLER waits for the return flush
        tick(1, 0, 0, 0);
        idle_n(4);
        exc_seen = 1'b0;
        tick(0, 1, 0, 0);
        idle_n(2);
        chk("t5_no_exc",  32'(exc_seen),  32'h0);
        chk("t5_pending", 32'(pending_o), 32'h2);
        tick(0, 0, 0, 1);
        run_until_exc(10, n);
        chk("t5_latency", 32'(n),       32'd4);
        chk("t5_cause",   32'(cause_o), 32'h1);
        idle_n(3);
        tick(0, 0, 0, 1);
        idle_n(3);

        // 6: asynchronous reset during FLUSH
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_exception", 32'(exception_o), 32'h0);
        chk("t6_stall",     32'(stall_o),     32'h0);
        chk("t6_redirect",  32'(redirect_o),  32'h0);
        chk("t6_pending",   32'(pending_o),   32'h0);
        model_reset();
        #2;
        rst = 1'b1;
        exc_seen = 1'b0;
        idle_n(6);
        chk("t6_no_pulse", 32'(exc_seen), 32'h0);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                status_i = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15))
                                                       : 32'h0000_000F;
            end
            pc_i       = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            exc_addr_i = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            tick(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // overall time guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
